// File: rtl/stripe_pkg.sv
// Shared constants, fill-side state encoding and the lane-count decode
// used by the byte striping transmitter.
package stripe_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LANES  = 4;

    localparam logic [1:0] LANE_MODE_1 = 2'd0;
    localparam logic [1:0] LANE_MODE_2 = 2'd1;
    localparam logic [1:0] LANE_MODE_4 = 2'd2;
    localparam logic [1:0] LANE_MODE_8 = 2'd3;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_ACTIVE,
        FILL_HELD
    } fill_state_t;

    // Lanes requested by the mode, never more than the block physically has.
    function automatic logic [3:0] lane_count(input logic [1:0] mode, input int lanes);
        logic [3:0] n;
        case (mode)
            LANE_MODE_1: n = 4'd1;
            LANE_MODE_2: n = 4'd2;
            LANE_MODE_4: n = 4'd4;
            LANE_MODE_8: n = 4'd8;
            default:     n = 4'd1;
        endcase
        if (int'(n) > lanes) begin
            n = 4'(lanes);
        end
        return n;
    endfunction

endpackage

// File: rtl/byte_stripe_tx_n_if.sv
// Byte input, row output and status signals of the striping transmitter;
// master drives bytes and consumes rows, slave is the transmitter itself.
interface byte_stripe_tx_n_if
    import stripe_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LANES  = DEFAULT_LANES
);

    logic                    valid;
    logic [DATA_W-1:0]       data;
    logic                    flush;
    logic [1:0]              lane_mode;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES-1:0]        lane_valid;
    logic [15:0]             row_count;

    modport master (
        output valid, data, flush, lane_mode, out_ready,
        input  in_ready, out_valid, out_data, lane_valid, row_count
    );

    modport slave (
        input  valid, data, flush, lane_mode, out_ready,
        output in_ready, out_valid, out_data, lane_valid, row_count
    );

endinterface

// File: rtl/stripe_row_buf.sv
// One row of LANES byte lanes with a per-lane valid mask; supports a
// whole-row load, a clear and a single-lane write by index.
module stripe_row_buf #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [LANES*DATA_W-1:0] load_data,
    input  logic [LANES-1:0]        load_mask,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [3:0]              wr_idx,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [LANES*DATA_W-1:0] row_data,
    output logic [LANES-1:0]        row_mask
);

    // Load beats clear beats write, so a row handed on and a new byte in the
    // same cycle never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_data <= '0;
            row_mask <= '0;
        end else if (load) begin
            row_data <= load_data;
            row_mask <= load_mask;
        end else if (clear) begin
            row_data <= '0;
            row_mask <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_idx == 4'(i)) begin
                    row_data[i*DATA_W +: DATA_W] <= wr_data;
                    row_mask[i]                  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/byte_stripe_tx_n.sv
// Stripes an input byte stream round-robin across up to LANES output lanes,
// one fill row feeding one output row with a ready/valid handshake.
module byte_stripe_tx_n
    import stripe_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LANES  = DEFAULT_LANES
) (
    input  logic              clk,
    input  logic              reset,
    byte_stripe_tx_n_if.slave bus
);

    fill_state_t             state, next_state;
    logic [3:0]              wr_ptr, row_n, n_eff;
    logic                    in_ready, acc, last_lane, complete;
    logic                    out_valid, out_free, out_fire, out_load, held_release;
    logic [LANES*DATA_W-1:0] fill_data, merged_data, out_row;
    logic [LANES-1:0]        fill_mask, merged_mask, out_mask;
    logic [15:0]             row_cnt;

    // Lane count is only taken from lane_mode at the start of a row.
    assign n_eff     = (wr_ptr == 4'd0) ? lane_count(bus.lane_mode, LANES) : row_n;
    assign acc       = bus.valid && in_ready;
    assign last_lane = (wr_ptr == n_eff - 4'd1);
    assign complete  = (state == FILL_ACTIVE) &&
                       ((acc && (last_lane || bus.flush)) ||
                        (!acc && bus.flush && (wr_ptr != 4'd0)));

    assign out_valid = |out_mask;
    assign out_fire  = out_valid && bus.out_ready;
    assign out_free  = !out_valid || bus.out_ready;
    assign out_load  = (complete && out_free) || held_release;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL_IDLE:   next_state = FILL_ACTIVE;
            FILL_ACTIVE: if (complete && !out_free) next_state = FILL_HELD;
            FILL_HELD:   if (bus.out_ready) next_state = FILL_ACTIVE;
            default:     next_state = FILL_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = 1'b0;
        held_release = 1'b0;
        case (state)
            FILL_ACTIVE: in_ready = 1'b1;
            FILL_HELD:   held_release = bus.out_ready;
            default:     ;
        endcase
    end

    // The completing byte is merged in here so a row can leave on the same edge.
    always_comb begin
        merged_data = fill_data;
        merged_mask = fill_mask;
        for (int i = 0; i < LANES; i++) begin
            if (acc && (wr_ptr == 4'(i))) begin
                merged_data[i*DATA_W +: DATA_W] = bus.data;
                merged_mask[i]                  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= 4'd0;
            row_n   <= 4'd0;
            row_cnt <= 16'd0;
        end else begin
            if (complete) begin
                wr_ptr <= 4'd0;
            end else if (acc) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (acc && (wr_ptr == 4'd0)) begin
                row_n <= n_eff;
            end
            if (out_fire) begin
                row_cnt <= row_cnt + 16'd1;
            end
        end
    end

    stripe_row_buf #(.DATA_W(DATA_W), .LANES(LANES)) u_fill (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .load_data ('0),
        .load_mask ('0),
        .clear     (out_load),
        .wr_en     (acc),
        .wr_idx    (wr_ptr),
        .wr_data   (bus.data),
        .row_data  (fill_data),
        .row_mask  (fill_mask)
    );

    stripe_row_buf #(.DATA_W(DATA_W), .LANES(LANES)) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (out_load),
        .load_data (merged_data),
        .load_mask (merged_mask),
        .clear     (out_fire),
        .wr_en     (1'b0),
        .wr_idx    (4'd0),
        .wr_data   ('0),
        .row_data  (out_row),
        .row_mask  (out_mask)
    );

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_row;
    assign bus.lane_valid = out_mask;
    assign bus.row_count  = row_cnt;

endmodule

// File: tb/tb_byte_stripe_tx_n.sv
// Directed bench for byte_stripe_tx_n: a queue-based row model checked every
// cycle, plus hand-computed rows pinned per scenario.
module tb_byte_stripe_tx_n;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;

    typedef logic [DATA_W-1:0] byte_q_t[$];

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    byte_stripe_tx_n_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

    byte_stripe_tx_n #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    byte_q_t     m_fill;
    byte_q_t     m_out;
    bit          m_held = 1'b0;
    bit          m_live = 1'b0;
    bit          m_acc  = 1'b0;
    int          m_n    = 1;
    logic [15:0] m_rows = 16'd0;

    logic [LANES*DATA_W-1:0] cap_d[$];
    logic [LANES-1:0]        cap_m[$];

    function automatic int model_lanes(input logic [1:0] mode);
        int n;
        n = 1 << mode;
        return (n > LANES) ? LANES : n;
    endfunction

    function automatic logic [LANES*DATA_W-1:0] row_word(input byte_q_t q);
        logic [LANES*DATA_W-1:0] w;
        w = '0;
        foreach (q[i]) w[i*DATA_W +: DATA_W] = q[i];
        return w;
    endfunction

    function automatic logic [LANES-1:0] row_bits(input byte_q_t q);
        logic [LANES-1:0] m;
        m = '0;
        foreach (q[i]) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Row-level model: a byte list being filled, one presented row, one held flag.
    always @(posedge clk or negedge rst_n) begin
        bit acc;
        bit fire;
        bit close;
        if (!rst_n) begin
            m_fill.delete();
            m_out.delete();
            m_held = 1'b0;
            m_live = 1'b0;
            m_acc  = 1'b0;
            m_rows = 16'd0;
        end else begin
            acc   = bus.valid && m_live && !m_held;
            fire  = (m_out.size() != 0) && bus.out_ready;
            m_acc = acc;
            if (fire) begin
                m_rows = m_rows + 16'd1;
                m_out.delete();
            end
            if (m_held) begin
                if (bus.out_ready) begin
                    m_out = m_fill;
                    m_fill.delete();
                    m_held = 1'b0;
                end
            end else if (m_live) begin
                if (acc) begin
                    if (m_fill.size() == 0) m_n = model_lanes(bus.lane_mode);
                    m_fill.push_back(bus.data);
                end
                close = (acc && ((m_fill.size() == m_n) || bus.flush)) ||
                        (!acc && bus.flush && (m_fill.size() != 0));
                if (close) begin
                    if (m_out.size() == 0) begin
                        m_out = m_fill;
                        m_fill.delete();
                    end else begin
                        m_held = 1'b1;
                    end
                end
            end
            m_live = 1'b1;
        end
    end

    always @(negedge clk) begin
        check_output("cyc_in_ready",   bus.in_ready,   m_live && !m_held);
        check_output("cyc_out_valid",  bus.out_valid,  m_out.size() != 0);
        check_output("cyc_out_data",   bus.out_data,   row_word(m_out));
        check_output("cyc_lane_valid", bus.lane_valid, row_bits(m_out));
        check_output("cyc_row_count",  bus.row_count,  m_rows);
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            cap_d.push_back(bus.out_data);
            cap_m.push_back(bus.lane_valid);
        end
    end

    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic f, input logic [1:0] mode);
        bus.valid     = v;
        bus.data      = d;
        bus.flush     = f;
        bus.lane_mode = mode;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic f, input logic [1:0] mode);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            apply_stimulus(1'b1, d, f, mode);
            got = m_acc;
        end
        check_output("send_accept", got, 1'b1);
    endtask

    task automatic idle(input int n, input logic [1:0] mode);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 8'h00, 1'b0, mode);
    endtask

    task automatic pop_row(input string name, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] ad;
        logic [3:0]  am;
        if (cap_d.size() == 0) begin
            ad = 'x;
            am = 'x;
        end else begin
            ad = cap_d.pop_front();
            am = cap_m.pop_front();
        end
        check_output({name, "_data"}, ad, d);
        check_output({name, "_mask"}, am, m);
    endtask

    task automatic do_reset();
        bus.valid = 1'b0;
        bus.flush = 1'b0;
        bus.data  = 8'h00;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_in_ready",   bus.in_ready,   1'b0);
        check_output("rst_out_valid",  bus.out_valid,  1'b0);
        check_output("rst_out_data",   bus.out_data,   32'h0);
        check_output("rst_lane_valid", bus.lane_valid, 4'h0);
        check_output("rst_row_count",  bus.row_count,  16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_release_in_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.valid     = 1'b0;
        bus.data      = 8'h00;
        bus.flush     = 1'b0;
        bus.lane_mode = 2'd2;
        bus.out_ready = 1'b1;
        do_reset();

        $display("[TB] four-lane streaming");
        for (int b = 1; b <= 8; b++) begin
            send_byte(8'(b), 1'b0, 2'd2);
            if (b == 4 || b == 8) begin
                check_output($sformatf("q33_valid_after_%0d", b), bus.out_valid, 1'b1);
            end
        end
        idle(3, 2'd2);
        pop_row("q33_row0", 32'h04030201, 4'hF);
        pop_row("q33_row1", 32'h08070605, 4'hF);

        $display("[TB] two-lane rows and flush");
        send_byte(8'h11, 1'b0, 2'd1);
        send_byte(8'h12, 1'b0, 2'd1);
        send_byte(8'h13, 1'b0, 2'd1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 2'd1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 2'd1);
        send_byte(8'h14, 1'b1, 2'd1);
        idle(3, 2'd1);
        pop_row("q34_row0", 32'h00001211, 4'b0011);
        pop_row("q34_row1", 32'h00000013, 4'b0001);
        pop_row("q34_flush_byte", 32'h00000014, 4'b0001);
        check_output("q34_extra_rows", cap_d.size(), 0);

        $display("[TB] eight-lane mode clamped");
        for (int b = 8'h51; b <= 8'h54; b++) send_byte(8'(b), 1'b0, 2'd3);
        idle(3, 2'd3);
        pop_row("clamp_row", 32'h54535251, 4'hF);

        $display("[TB] lane mode change mid-row");
        send_byte(8'h31, 1'b0, 2'd2);
        send_byte(8'h32, 1'b0, 2'd2);
        send_byte(8'h33, 1'b0, 2'd0);
        send_byte(8'h34, 1'b0, 2'd0);
        send_byte(8'h35, 1'b0, 2'd0);
        idle(3, 2'd0);
        pop_row("q36_row0", 32'h34333231, 4'hF);
        pop_row("q36_row1", 32'h00000035, 4'h1);

        $display("[TB] backpressure stall");
        bus.out_ready = 1'b0;
        for (int b = 8'h21; b <= 8'h28; b++) send_byte(8'(b), 1'b0, 2'd2);
        check_output("q35_in_ready_low", bus.in_ready, 1'b0);
        idle(3, 2'd2);
        check_output("q35_no_rows_yet", cap_d.size(), 0);
        bus.out_ready = 1'b1;
        idle(4, 2'd2);
        pop_row("q35_row0", 32'h24232221, 4'hF);
        pop_row("q35_row1", 32'h28272625, 4'hF);

        $display("[TB] reset mid-row");
        bus.out_ready = 1'b0;
        for (int b = 8'h45; b <= 8'h48; b++) send_byte(8'(b), 1'b0, 2'd2);
        send_byte(8'h41, 1'b0, 2'd2);
        send_byte(8'h42, 1'b0, 2'd2);
        send_byte(8'h43, 1'b0, 2'd2);
        do_reset();
        bus.out_ready = 1'b1;
        send_byte(8'hAA, 1'b1, 2'd2);
        idle(3, 2'd2);
        pop_row("q37_aa", 32'h000000AA, 4'h1);
        check_output("q37_extra_rows", cap_d.size(), 0);

        $display("[TB] row counter wrap");
        do_reset();
        for (int r = 0; r < 65537; r++) begin
            send_byte(8'(r), 1'b0, 2'd0);
        end
        idle(3, 2'd0);
        check_output("q38_row_count", bus.row_count, 16'd1);
        cap_d.delete();
        cap_m.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_stripe_tx_n.md
BYTE_STRIPE_TX_N -- requirements
Module: byte_stripe_tx_n

Interface
REQ-001 Parameter DATA_W, default 8, width of one byte lane in bits.
REQ-002 Parameter LANES, default 4, number of output lanes; SHALL be 1, 2, 4 or 8.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port valid  input  1  input byte present on data this cycle.
REQ-006 Port data  input  DATA_W  input byte.
REQ-007 Port flush  input  1  closes the current partial row.
REQ-008 Port lane_mode  input  2  active lane count encoding: 0=1, 1=2, 2=4, 3=8 lanes.
REQ-009 Port in_ready  output  1  block accepts a byte this cycle.
REQ-010 Port out_valid  output  1  out_data row presented.
REQ-011 Port out_ready  input  1  downstream accepts the presented row.
REQ-012 Port out_data  output  LANES*DATA_W  striped row; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-013 Port lane_valid  output  LANES  per-lane byte-present mask for the presented row.
REQ-014 Port row_count  output  16  number of rows accepted downstream, wrapping.

Function
REQ-015 Input accepts on valid && in_ready; output transfers on out_valid && out_ready.
REQ-016 Active lane count N = decoded lane_mode, clamped to LANES.
REQ-017 N is sampled only when the fill pointer is 0; a change mid-row takes effect on the next row.
REQ-018 Accepted bytes are written round-robin into a fill row at lane wr_ptr, wr_ptr = 0..N-1; the first byte of a row goes to lane 0.
REQ-019 A row completes when a byte is accepted at wr_ptr = N-1, or when flush is high with wr_ptr > 0.
REQ-020 flush together with an accepted byte: that byte is included and the row then closes; flush with wr_ptr = 0 and no accepted byte has no effect.
REQ-021 On completion, if the output stage is empty or out_ready is high that cycle, the row moves to the output stage on the same edge; out_valid is therefore high in the cycle after the final byte is accepted.
REQ-022 Otherwise the fill row is held full; in_ready is low until the transfer, and the transfer occurs on the edge where out_ready is high.
REQ-023 in_ready is low only while a completed fill row is held; a one-row stall never loses or reorders bytes.
REQ-024 lane_valid bits are 1 for the filled lanes only; unfilled and inactive lanes drive zero data and lane_valid 0.
REQ-025 out_valid, out_data and lane_valid stay stable until accepted.
REQ-026 row_count increments by 1 on each output transfer and wraps from 16'hFFFF to 0.
REQ-027 wr_ptr returns to 0 after every row completion.

Reset
REQ-028 While reset is low: in_ready=0, out_valid=0, out_data=0, lane_valid=0, row_count=0, wr_ptr=0, fill row cleared.
REQ-029 in_ready rises in the first cycle after reset deasserts.
REQ-030 Reset mid-row discards the partial row and any presented row without emitting them.

Structure
REQ-031 Package stripe_pkg holds the lane_mode encoding constants, the lane-count decode function and the default DATA_W and LANES values.
REQ-032 A single sub-module, stripe_row_buf, holds one LANES*DATA_W row with its per-lane valid mask and write-by-index port; it is instantiated twice (fill and output).

Verification
REQ-033 LANES=4, lane_mode=2, bytes 01..08 streamed with out_ready=1 -> rows {04,03,02,01} then {08,07,06,05}, lane_valid=4'hF, out_valid one cycle after bytes 04 and 08.
REQ-034 lane_mode=1, bytes 11,12,13 then flush -> row {12,11} with mask 4'b0011, then row {13} with mask 4'b0001.
REQ-035 lane_mode=2, out_ready=0, 8 bytes offered -> first row is held, second row fills, in_ready falls after the 8th byte; raising out_ready drains both rows in order.
REQ-036 lane_mode changed 2->0 after 2 of 4 bytes -> current row still completes at 4 lanes, and the next row uses 1 lane.
REQ-037 Reset asserted after 3 bytes of a row -> no row emitted; after release, byte AA lands on lane 0.
REQ-038 65537 single-lane rows transferred -> row_count=1.
